// File: rtl/reflexgame_pkg.sv
// Shared definitions for the reflex minigame: state codes, default timing and a one-hot helper.
package reflexgame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PREP   = 4'd1,
        ST_ESPERA = 4'd2,
        ST_MOSTRA = 4'd3,
        ST_ACERTO = 4'd4,
        ST_ERRO   = 4'd5,
        ST_FIM    = 4'd6
    } estado_t;

    localparam int PAUSA_PADRAO           = 500;
    localparam int TIMEOUT_FACIL_PADRAO   = 1500;
    localparam int TIMEOUT_DIFICIL_PADRAO = 700;
    localparam int RODADAS_PADRAO         = 7;

    localparam int         LARG_TIMER   = 16;
    localparam logic [6:0] JOGADAS_ERRO = 7'h7F;

    // Index 7 is not a button and maps to an all-zero pattern.
    function automatic logic [6:0] um_quente(input logic [2:0] idx);
        logic [7:0] t;
        t = 8'd1 << idx;
        return t[6:0];
    endfunction

endpackage

// File: rtl/reflexgame_timer.sv
// Loadable up-counter with clear and enable; fim flags when the count equals the limit.
module reflexgame_timer
    import reflexgame_pkg::*;
#(
    parameter int LARGURA = LARG_TIMER
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               en,
    input  logic [LARGURA-1:0] valor,
    input  logic [LARGURA-1:0] limite,
    output logic               fim
);

    logic [LARGURA-1:0] contagem;

    assign fim = (contagem == limite);

    // Count holds at the limit so a stalled consumer still sees fim.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (en && !fim) begin
            contagem <= contagem + 1'b1;
        end
    end

endmodule

// File: rtl/reflexgame.sv
// Reflex minigame: lights one of 7 buttons per round and scores timely presses.
// Build option REFLEXGAME_PENALIDADE_EN: a miss decrements the score (saturating at 0).
//
// state  | meaning
// IDLE   | waiting for jogar after reset
// PREP   | new game accepted, score and round cleared
// ESPERA | blank gap before the target; any press is early
// MOSTRA | target lit, waiting for the matching press or timeout
// ACERTO | correct press, score up
// ERRO   | wrong, early or missing press
// FIM    | game over, pronto high, waiting for jogar
module reflexgame
    import reflexgame_pkg::*;
#(
    parameter int PAUSA           = PAUSA_PADRAO,
    parameter int TIMEOUT_FACIL   = TIMEOUT_FACIL_PADRAO,
    parameter int TIMEOUT_DIFICIL = TIMEOUT_DIFICIL_PADRAO,
    parameter int RODADAS         = RODADAS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       dificuldade,
    input  logic [6:0] botoes,
    output logic [3:0] estado,
    output logic [6:0] jogadas,
    output logic [2:0] pontuacao,
    output logic       pronto
);

    localparam logic [LARG_TIMER-1:0] LIM_PAUSA   = LARG_TIMER'(PAUSA);
    localparam logic [LARG_TIMER-1:0] LIM_FACIL   = LARG_TIMER'(TIMEOUT_FACIL);
    localparam logic [LARG_TIMER-1:0] LIM_DIFICIL = LARG_TIMER'(TIMEOUT_DIFICIL);
    localparam logic [LARG_TIMER-1:0] CARGA_UM    = LARG_TIMER'(1);
    localparam logic [3:0]            RODADAS_4   = 4'(RODADAS);

    estado_t              st;
    logic [6:0]           botoes_q;
    logic [6:0]           borda;
    logic [6:0]           alvo_oh;
    logic [2:0]           cont7;
    logic [2:0]           alvo;
    logic [2:0]           rodada;
    logic [2:0]           score;
    logic                 dif_q;
    logic                 ultima;
    logic                 tm_clear;
    logic                 tm_load;
    logic                 tm_en;
    logic                 tm_fim;
    logic [LARG_TIMER-1:0] tm_limite;

    assign borda   = botoes & ~botoes_q;
    assign alvo_oh = um_quente(alvo);
    assign ultima  = (({1'b0, rodada} + 4'd1) == RODADAS_4);

    assign estado    = st;
    assign pontuacao = score;

    // Timer is loaded with 1 on entry to ESPERA/MOSTRA so fim rises in the N-th cycle.
    assign tm_clear  = (st == ST_IDLE) || (st == ST_FIM);
    assign tm_load   = (st == ST_PREP) || (st == ST_ACERTO) || (st == ST_ERRO) ||
                       ((st == ST_ESPERA) && tm_fim);
    assign tm_en     = (st == ST_ESPERA) || (st == ST_MOSTRA);
    assign tm_limite = (st == ST_MOSTRA) ? (dif_q ? LIM_DIFICIL : LIM_FACIL) : LIM_PAUSA;

    reflexgame_timer #(
        .LARGURA (LARG_TIMER)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tm_clear),
        .load   (tm_load),
        .en     (tm_en),
        .valor  (CARGA_UM),
        .limite (tm_limite),
        .fim    (tm_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botoes_q <= '0;
            cont7    <= '0;
        end else begin
            botoes_q <= botoes;
            cont7    <= (cont7 == 3'd6) ? 3'd0 : cont7 + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st      <= ST_IDLE;
            jogadas <= '0;
            score   <= '0;
            pronto  <= 1'b0;
            rodada  <= '0;
            alvo    <= '0;
            dif_q   <= 1'b0;
        end else begin
            case (st)
                ST_IDLE, ST_FIM: begin
                    if (jogar) begin
                        st      <= ST_PREP;
                        dif_q   <= dificuldade;
                        score   <= '0;
                        rodada  <= '0;
                        pronto  <= 1'b0;
                        jogadas <= '0;
                    end
                end
                ST_PREP: begin
                    st      <= ST_ESPERA;
                    jogadas <= '0;
                end
                ST_ESPERA: begin
                    if (|borda) begin
                        st      <= ST_ERRO;
                        jogadas <= JOGADAS_ERRO;
                    end else if (tm_fim) begin
                        st      <= ST_MOSTRA;
                        alvo    <= cont7;
                        jogadas <= um_quente(cont7);
                    end
                end
                ST_MOSTRA: begin
                    // A press on the timeout cycle still counts as a press.
                    if (|borda) begin
                        if (borda == alvo_oh) begin
                            st <= ST_ACERTO;
                        end else begin
                            st      <= ST_ERRO;
                            jogadas <= JOGADAS_ERRO;
                        end
                    end else if (tm_fim) begin
                        st      <= ST_ERRO;
                        jogadas <= JOGADAS_ERRO;
                    end
                end
                ST_ACERTO, ST_ERRO: begin
                    if (st == ST_ACERTO) begin
                        if (score != 3'd7) begin
                            score <= score + 3'd1;
                        end
                    end else begin
`ifdef REFLEXGAME_PENALIDADE_EN
                        if (score != 3'd0) begin
                            score <= score - 3'd1;
                        end
`else
                        score <= score;
`endif
                    end
                    rodada  <= rodada + 3'd1;
                    jogadas <= '0;
                    if (ultima) begin
                        st     <= ST_FIM;
                        pronto <= 1'b1;
                    end else begin
                        st <= ST_ESPERA;
                    end
                end
                default: begin
                    st      <= ST_IDLE;
                    jogadas <= '0;
                    pronto  <= 1'b0;
                end
            endcase
        end
    end

endmodule
